// File: rtl/fetch_input_data.sv
// fetch_input_data: reads a PS-filled BRAM buffer sequentially and streams it out over valid/ready.
// Optional abort input is compiled in when FETCH_INPUT_ABORT_EN is defined.

module fetch_input_data #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              resetn,
`ifdef FETCH_INPUT_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_din,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              last_out,
    output logic              busy,
    output logic              done
);

    localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CW = $clog2(FIFO_D + RD_LAT + 1);
    localparam logic [ADDR_W:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nx;
    logic [ADDR_W:0]     len_q, rd_cnt, out_cnt;
    logic [RD_LAT:1]     vld_pipe;
    logic [CW-1:0]       in_flight, fifo_cnt;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [DATA_W-1:0]   mem [FIFO_D];
    logic                abort_i, flush, rd_ok, wr, xfer, is_last;

`ifdef FETCH_INPUT_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign flush     = abort_i && (state != IDLE);
    assign valid_out = (fifo_cnt != '0);
    assign data_out  = mem[rd_ptr];
    assign xfer      = valid_out && ready_in;
    assign is_last   = (out_cnt == len_q - ONE);
    assign last_out  = valid_out && is_last;
    assign wr        = vld_pipe[RD_LAT];
    assign bram_addr = rd_cnt[ADDR_W-1:0];
    assign bram_we   = 1'b0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (length == '0) ? DONE : RUN;
            RUN:     if (xfer && is_last)      state_nx = DONE;
                     else if (rd_cnt == len_q) state_nx = DRAIN;
            DRAIN:   if (xfer && is_last)      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // Credit check: FIFO entries plus reads still in the BRAM pipe must fit in the FIFO.
    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE) && !abort_i;
        rd_ok   = (state == RUN) && (rd_cnt < len_q) && !abort_i &&
                  ((fifo_cnt + in_flight) < CW'(FIFO_D));
        bram_en = rd_ok;
    end

    always_comb begin
        in_flight = '0;
        for (int i = 1; i <= RD_LAT; i++) in_flight = in_flight + CW'(vld_pipe[i]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_q   <= '0;
            rd_cnt  <= '0;
            out_cnt <= '0;
        end else if (state == IDLE && start) begin
            len_q   <= length;
            rd_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (rd_ok) rd_cnt  <= rd_cnt + ONE;
            if (xfer)  out_cnt <= out_cnt + ONE;
        end
    end

    // Read-return tracker: a bit enters at issue and reaches the top when bram_din is valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            for (int i = RD_LAT; i > 1; i--) vld_pipe[i] <= vld_pipe[i-1];
            vld_pipe[1] <= rd_ok;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_D; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= bram_din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (xfer) rd_ptr <= rd_ptr + PW'(1);
            case ({wr, xfer})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_input_data.sv
// Scoreboard bench for fetch_input_data: two instances (RD_LAT=1 and RD_LAT=2) driven in lockstep.
// Directed transfers push expected words; a negedge monitor pops and compares.

module tb_fetch_input_data;

    logic        clk, resetn, start, ready_in;
    logic [10:0] length;
    logic [9:0]  addr [2];
    logic        en [2], we [2], vout [2], last [2], busy [2], done [2];
    logic [7:0]  din [2], dout [2];
`ifdef FETCH_INPUT_ABORT_EN
    logic        abort;
`endif

    int n_chk = 0, n_fail = 0;
    int mode = 0, cyc = 0;
    int q0[$], q1[$];
    int done_cnt [2], dbase [2], xfer_n [2], first_cyc [2], last_cyc [2];
    int en_cnt [2];
    int hits0 [1024], hits1 [1024];
    logic       stg_v;
    logic [7:0] stg_d;

    fetch_input_data #(.RD_LAT(1)) u0 (
        .clk(clk), .resetn(resetn),
`ifdef FETCH_INPUT_ABORT_EN
        .abort(abort),
`endif
        .start(start), .length(length), .bram_addr(addr[0]), .bram_en(en[0]),
        .bram_we(we[0]), .bram_din(din[0]), .data_out(dout[0]), .valid_out(vout[0]),
        .ready_in(ready_in), .last_out(last[0]), .busy(busy[0]), .done(done[0]));

    fetch_input_data #(.RD_LAT(2)) u1 (
        .clk(clk), .resetn(resetn),
`ifdef FETCH_INPUT_ABORT_EN
        .abort(abort),
`endif
        .start(start), .length(length), .bram_addr(addr[1]), .bram_en(en[1]),
        .bram_we(we[1]), .bram_din(din[1]), .data_out(dout[1]), .valid_out(vout[1]),
        .ready_in(ready_in), .last_out(last[1]), .busy(busy[1]), .done(done[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM models holding BRAM[i] = i (low 8 bits)
    always @(posedge clk) begin
        if (en[0]) begin
            din[0] <= addr[0][7:0];
            hits0[addr[0]] <= hits0[addr[0]] + 1;
            en_cnt[0] <= en_cnt[0] + 1;
        end
        stg_v <= en[1];
        stg_d <= addr[1][7:0];
        din[1] <= stg_d;
        if (en[1]) begin
            hits1[addr[1]] <= hits1[addr[1]] + 1;
            en_cnt[1] <= en_cnt[1] + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rc = 0;
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_in = (mode == 0) ? 1'b1 : (rc % 3 == 0);
            rc++;
        end
    end

    // Monitor: pops the scoreboard on every accepted word and checks stall stability.
    initial begin
        logic       prev_r;
        logic       prev_v [2];
        logic [7:0] prev_d [2];
        int         e;
        prev_r = 1'b0;
        prev_v[0] = 1'b0; prev_v[1] = 1'b0;
        prev_d[0] = '0;   prev_d[1] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!resetn) begin
                    prev_v[k] = 1'b0;
                end else begin
                    if (done[k]) done_cnt[k]++;
                    if (prev_v[k] && !prev_r) begin
                        chk($sformatf("hold_valid%0d", k), int'(vout[k]), 1);
                        chk($sformatf("hold_data%0d", k), int'(dout[k]), int'(prev_d[k]));
                    end
                    if (vout[k] && ready_in) begin
                        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                            chk($sformatf("unexpected_word%0d", k), int'(dout[k]), -1);
                        end else begin
                            e = (k == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("data%0d", k), int'(dout[k]), e & 8'hff);
                            chk($sformatf("last%0d", k), int'(last[k]), e >> 8);
                        end
                        if (xfer_n[k] == 0) first_cyc[k] = cyc;
                        last_cyc[k] = cyc;
                        xfer_n[k]++;
                    end
                    prev_v[k] = vout[k];
                    prev_d[k] = dout[k];
                end
            end
            prev_r = ready_in;
        end
    end

    task automatic go(input int len);
        for (int i = 0; i < len; i++) begin
            q0.push_back(((i == len - 1) ? 256 : 0) | (i & 8'hff));
            q1.push_back(((i == len - 1) ? 256 : 0) | (i & 8'hff));
        end
        for (int k = 0; k < 2; k++) begin
            xfer_n[k] = 0;
            dbase[k]  = done_cnt[k];
        end
        start  = 1'b1;
        length = 11'(len);
        tick;
        start  = 1'b0;
        length = 11'd5;
    endtask

    task automatic wait_done(input int len);
        int n = 0;
        while ((done_cnt[0] <= dbase[0] || done_cnt[1] <= dbase[1]) && n < 3000) begin
            tick;
            n++;
        end
        chk("done_within_budget", int'(n < 3000), 1);
        repeat (3) tick;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("done_once%0d", k), done_cnt[k] - dbase[k], 1);
            chk($sformatf("word_count%0d", k), xfer_n[k], len);
            chk($sformatf("busy_clear%0d", k), int'(busy[k]), 0);
        end
        chk("queue0_empty", q0.size(), 0);
        chk("queue1_empty", q1.size(), 0);
    endtask

    task automatic wait_words(input int n);
        int c = 0;
        while (xfer_n[0] < n && c < 500) begin
            tick;
            c++;
        end
        chk("words_within_budget", int'(c < 500), 1);
    endtask

    initial begin
        int e0, e1, bad;
        int h0 [1024];
        int h1 [1024];
        resetn = 1'b0;
        start  = 1'b0;
        length = '0;
`ifdef FETCH_INPUT_ABORT_EN
        abort  = 1'b0;
`endif
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0; xfer_n[k] = 0; en_cnt[k] = 0;
        end
        for (int i = 0; i < 1024; i++) begin
            hits0[i] = 0; hits1[i] = 0;
        end
        repeat (3) tick;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid%0d", k), int'(vout[k]), 0);
            chk($sformatf("rst_busy%0d", k),  int'(busy[k]), 0);
            chk($sformatf("rst_done%0d", k),  int'(done[k]), 0);
            chk($sformatf("rst_en%0d", k),    int'(en[k]), 0);
            chk($sformatf("rst_last%0d", k),  int'(last[k]), 0);
            chk($sformatf("rst_we%0d", k),    int'(we[k]), 0);
        end
        tick;
        resetn = 1'b1;
        repeat (2) tick;

        // full-rate 16-word transfer
        go(16);
        chk("busy_after_start", int'(busy[0]), 1);
        wait_done(16);
        chk("burst_span0", last_cyc[0] - first_cyc[0], 15);
        chk("burst_span1", last_cyc[1] - first_cyc[1], 15);

        // backpressure: ready high one cycle in three
        mode = 1;
        go(8);
        wait_done(8);
        mode = 0;
        tick;

        // zero length: done next cycle, no reads, no words
        e0 = en_cnt[0]; e1 = en_cnt[1];
        go(0);
        @(negedge clk);
        chk("len0_done0", int'(done[0]), 1);
        chk("len0_done1", int'(done[1]), 1);
        wait_done(0);
        chk("len0_no_read0", en_cnt[0] - e0, 0);
        chk("len0_no_read1", en_cnt[1] - e1, 0);

        // start re-pulsed mid-transfer is ignored
        go(10);
        wait_words(5);
        start = 1'b1;
        length = 11'd3;
        tick;
        start = 1'b0;
        wait_done(10);
        repeat (4) tick;
        chk("repulse_no_extra_done0", done_cnt[0] - dbase[0], 1);

        // full address range, every address read exactly once
        for (int i = 0; i < 1024; i++) begin
            h0[i] = hits0[i]; h1[i] = hits1[i];
        end
        go(1024);
        wait_done(1024);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (hits0[i] - h0[i] != 1) bad++;
            if (hits1[i] - h1[i] != 1) bad++;
        end
        chk("addr_each_once", bad, 0);

        // reset mid-transfer, then a fresh 4-word transfer
        go(10);
        wait_words(3);
        resetn = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("rst_mid_valid0", int'(vout[0]), 0);
        chk("rst_mid_valid1", int'(vout[1]), 0);
        chk("rst_mid_busy0", int'(busy[0]), 0);
        chk("rst_mid_busy1", int'(busy[1]), 0);
        tick;
        resetn = 1'b1;
        repeat (3) tick;
        chk("rst_mid_no_done0", done_cnt[0] - dbase[0], 0);
        chk("rst_mid_no_done1", done_cnt[1] - dbase[1], 0);
        go(4);
        wait_done(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
